// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between instruction fetch
// and data load/store, with starvation-bounded fetch priority.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_sign_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_sign_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW  = 2;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   starve_q,    starve_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   d_rdata_q,   d_rdata_d;
  logic            if_ack_q,    if_ack_d;
  logic            d_ack_q,     d_ack_d;
  logic            d_err_q,     d_err_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_sign_q,  mem_sign_d;
  logic [BEW-1:0]  mem_be_q,    mem_be_d;

  logic            is_byte_c;
  logic            is_half_c;
  logic            is_word_c;
  logic            misal_c;
  logic [BEW-1:0]  be_c;
  logic            starved_c;
  logic            grant_i_c;
  logic            grant_d_c;
  logic            unused_addr_bits;

  // Fetch words are always aligned, so the low fetch address bits are dropped.
  assign unused_addr_bits = ^if_addr_i[1:0];

  // Data access size, alignment and lane decode.
  always_comb begin
    is_byte_c = (d_size_i == 2'b00);
    is_half_c = (d_size_i == 2'b01);
    is_word_c = d_size_i[1];
    misal_c   = (is_half_c & d_addr_i[0]) | (is_word_c & (d_addr_i[1:0] != 2'b00));
    be_c      = 4'b1111;
    if (is_byte_c) begin
      be_c = 4'b0001 << d_addr_i[1:0];
    end else if (is_half_c) begin
      be_c = d_addr_i[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Data normally wins; a fetch that has lost STARVE_MAX times in a row wins.
  always_comb begin
    starved_c = (starve_q == STARVE_LIM);
    grant_i_c = if_req_i & (~d_req_i | starved_c);
    grant_d_c = d_req_i & ~grant_i_c;
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_sign_d  = 1'b0;
    mem_be_d    = '0;

    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d     = D_ACC;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          mem_sign_d  = d_sign_i;
          mem_read_d  = ~d_we_i & ~misal_c;
          mem_write_d = d_we_i & ~misal_c;
          mem_be_d    = misal_c ? '0 : be_c;
          if (if_req_i && (starve_q != {CW{1'b1}})) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (grant_i_c) begin
          state_d    = I_ACC;
          mem_addr_d = {if_addr_i[AW-1:2], 2'b00};
          mem_read_d = 1'b1;
          mem_be_d   = '1;
          starve_d   = '0;
        end
      end
      D_ACC: begin
        state_d = DONE;
        d_ack_d = 1'b1;
        d_err_d = misal_c;
        if (misal_c) begin
          d_rdata_d = '0;
        end else if (!d_we_i) begin
          d_rdata_d = mem_rdata_i;
        end
      end
      I_ACC: begin
        state_d    = DONE;
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata_i;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_sign_q  <= 1'b0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_sign_q  <= mem_sign_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_err_o     = d_err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_read_o  = mem_read_q;
  // A store is never presented to memory while reset is asserted.
  assign mem_write_o = mem_write_q & rst_n;
  assign mem_sign_o  = mem_sign_q;
  assign mem_be_o    = mem_be_q;

endmodule
